// File: rtl/pipeline_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard/sequencing controller.
//   NENT      scoreboard depth (EX, MEM, WB)
//   ENTW      scoreboard entry width {v, reg[2:0]}
//   ctrlState halt-sequencing FSM encodings
//   sbEntry   one scoreboard entry
package pipe_ctrl_pkg;

   localparam int NENT = 3;
   localparam int ENTW = 4;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } ctrlState;

   typedef struct packed {
      logic            v;
      logic [ENTW-2:0] rd;
   } sbEntry;

endpackage

// File: rtl/pipeline_ctrl_sb_match.sv
// sb_match: compares one source register against every scoreboard entry.
//   src      source register number
//   entries  scoreboard contents, index 0 = EX
//   hit      some valid entry targets src
module sb_match
   import pipe_ctrl_pkg::*;
(
   input  logic [2:0]          src,
   input  sbEntry [NENT-1:0]   entries,
   output logic                hit
);

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < NENT; i++)
         hit = hit | (entries[i].v & (entries[i].rd == src));
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: RAW-hazard stall, branch flush and halt-drain control for the five-stage pipeline.
//   clk, rst (async, active-low)
//   idValid/idSrc1/idSrc2/idSrc1Used/idSrc2Used/idRegWrt/idWriteReg/idHalt  decode-stage instruction
//   exDoBranch  taken branch/jump resolved; memBusy  freeze the whole pipeline
//   stallFetch/stallDecode/bubble/flushPipe  stage controls
//   haltDone  halted and drained; stallCnt  saturating hazard-stall count; err  sticky protocol error
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        idValid,
   input  logic [2:0]  idSrc1,
   input  logic [2:0]  idSrc2,
   input  logic        idSrc1Used,
   input  logic        idSrc2Used,
   input  logic        idRegWrt,
   input  logic [2:0]  idWriteReg,
   input  logic        idHalt,
   input  logic        exDoBranch,
   input  logic        memBusy,
   output logic        stallFetch,
   output logic        stallDecode,
   output logic        bubble,
   output logic        flushPipe,
   output logic        haltDone,
   output logic [15:0] stallCnt,
   output logic        err
);

   sbEntry [NENT-1:0] sb;
   ctrlState          state, nextState;
   logic              pendFlush, hit1, hit2, hazard, flushReq, issue, sbEmpty;

   sb_match uMatch1 (.src(idSrc1), .entries(sb), .hit(hit1));
   sb_match uMatch2 (.src(idSrc2), .entries(sb), .hit(hit2));

   always_comb begin
      flushReq = exDoBranch | pendFlush;
      hazard   = idValid & ((idSrc1Used & hit1) | (idSrc2Used & hit2));
      issue    = idValid & ~hazard & ~memBusy & ~flushReq & (state == RUN);
      sbEmpty  = 1'b1;
      for (int i = 0; i < NENT; i++)
         sbEmpty = sbEmpty & ~sb[i].v;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         sb        <= '0;
         pendFlush <= 1'b0;
         stallCnt  <= 16'd0;
         err       <= 1'b0;
      end else begin
         // a branch seen while frozen is remembered until the first thawed cycle
         pendFlush <= memBusy & flushReq;
         err       <= err | (exDoBranch & (pendFlush | (state == HALTED)));
         if (!memBusy) begin
            sb[0] <= {issue & idRegWrt, idWriteReg};
            // the instruction leaving EX on a flush is wrong-path and never writes
            sb[1] <= flushReq ? '0 : sb[0];
            for (int i = 2; i < NENT; i++)
               sb[i] <= sb[i-1];
            if (hazard & (state == RUN) & (stallCnt != 16'hFFFF))
               stallCnt <= stallCnt + 16'd1;
         end
      end

   always_ff @(posedge clk or negedge rst)
      if (!rst)
         state <= RUN;
      else
         state <= nextState;

   always_comb begin
      nextState = state;
      if (!memBusy)
         case (state)
            RUN:     nextState = (issue & idHalt) ? DRAIN : RUN;
            // a flush during drain means the HALT was on the wrong path
            DRAIN:   nextState = flushReq ? RUN : (sbEmpty ? HALTED : DRAIN);
            default: nextState = HALTED;
         endcase
   end

   always_comb begin
      flushPipe   = flushReq & ~memBusy;
      bubble      = ~issue;
      stallDecode = memBusy | hazard | (state != RUN);
      stallFetch  = stallDecode;
      haltDone    = state == HALTED;
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed self-checking bench for pipeline_ctrl.
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        idValid, idSrc1Used, idSrc2Used, idRegWrt, idHalt, exDoBranch, memBusy;
   logic [2:0]  idSrc1, idSrc2, idWriteReg;
   logic        stallFetch, stallDecode, bubble, flushPipe, haltDone, err;
   logic [15:0] stallCnt;
   int          total = 0;
   int          passed = 0;
   int          failed = 0;

   pipeline_ctrl dut (
      .clk(clk), .rst(rst),
      .idValid(idValid), .idSrc1(idSrc1), .idSrc2(idSrc2),
      .idSrc1Used(idSrc1Used), .idSrc2Used(idSrc2Used),
      .idRegWrt(idRegWrt), .idWriteReg(idWriteReg), .idHalt(idHalt),
      .exDoBranch(exDoBranch), .memBusy(memBusy),
      .stallFetch(stallFetch), .stallDecode(stallDecode), .bubble(bubble),
      .flushPipe(flushPipe), .haltDone(haltDone), .stallCnt(stallCnt), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      idValid = 0; idSrc1Used = 0; idSrc2Used = 0; idRegWrt = 0; idHalt = 0;
      exDoBranch = 0; memBusy = 0; idSrc1 = 0; idSrc2 = 0; idWriteReg = 0;
   endtask

   task automatic nxt();
      @(negedge clk);
      clr();
   endtask

   task automatic wr(input logic [2:0] r);
      idValid = 1; idRegWrt = 1; idWriteReg = r;
   endtask

   task automatic rd1(input logic [2:0] r);
      idValid = 1; idSrc1Used = 1; idSrc1 = r;
   endtask

   task automatic rd2(input logic [2:0] r);
      idValid = 1; idSrc2Used = 1; idSrc2 = r;
   endtask

   initial begin
      clr();
      #1 rst = 0;
      #1;
      chk("rst_stallCnt", stallCnt, 0);
      chk("rst_err", {15'd0, err}, 0);
      chk("rst_haltDone", {15'd0, haltDone}, 0);
      chk("rst_flushPipe", {15'd0, flushPipe}, 0);
      chk("rst_stallDecode", {15'd0, stallDecode}, 0);
      chk("rst_bubble", {15'd0, bubble}, 1);
      @(negedge clk);
      rst = 1;

      // back-to-back RAW on r3
      nxt(); wr(3); #1 chk("raw_prod_issue", {15'd0, bubble}, 0);
      for (int i = 0; i < 3; i++) begin
         nxt(); rd1(3); wr(1); #1;
         chk("raw_stallDecode", {15'd0, stallDecode}, 1);
         chk("raw_stallFetch", {15'd0, stallFetch}, 1);
         chk("raw_bubble", {15'd0, bubble}, 1);
      end
      nxt(); rd1(3); wr(1); #1;
      chk("raw_cons_nostall", {15'd0, stallDecode}, 0);
      chk("raw_cons_issue", {15'd0, bubble}, 0);
      nxt(); #1 chk("raw_stallCnt", stallCnt, 3);
      repeat (3) nxt();

      // distance-2 consumer through source 2 stalls 2 cycles
      nxt(); wr(2); #1;
      nxt(); #1;
      for (int i = 0; i < 2; i++) begin
         nxt(); rd2(2); #1 chk("d2_stall", {15'd0, stallDecode}, 1);
      end
      nxt(); rd2(2); #1 chk("d2_issue", {15'd0, bubble}, 0);
      nxt(); #1 chk("d2_stallCnt", stallCnt, 5);
      repeat (3) nxt();

      // taken branch squashes the r5 writer in EX
      nxt(); wr(5); #1 chk("br_prod_issue", {15'd0, bubble}, 0);
      nxt(); exDoBranch = 1; #1;
      chk("br_flushPipe", {15'd0, flushPipe}, 1);
      chk("br_bubble", {15'd0, bubble}, 1);
      nxt(); rd1(5); #1;
      chk("br_flush_once", {15'd0, flushPipe}, 0);
      chk("br_r5_nostall", {15'd0, stallDecode}, 0);
      chk("br_r5_issue", {15'd0, bubble}, 0);
      repeat (3) nxt();

      // branch while memory busy for 4 cycles
      nxt(); memBusy = 1; exDoBranch = 1; #1;
      chk("busy_br_noflush", {15'd0, flushPipe}, 0);
      chk("busy_stall", {15'd0, stallDecode}, 1);
      for (int i = 0; i < 3; i++) begin
         nxt(); memBusy = 1; #1 chk("busy_noflush", {15'd0, flushPipe}, 0);
      end
      nxt(); #1;
      chk("busy_late_flush", {15'd0, flushPipe}, 1);
      chk("busy_err", {15'd0, err}, 0);
      nxt(); #1 chk("busy_flush_once", {15'd0, flushPipe}, 0);
      repeat (3) nxt();

      // halt on wrong path: flush during DRAIN returns to RUN
      nxt(); wr(1);
      nxt(); wr(2);
      nxt(); idValid = 1; idHalt = 1; #1 chk("hf_halt_issue", {15'd0, bubble}, 0);
      nxt(); exDoBranch = 1; #1;
      chk("hf_drain_stall", {15'd0, stallDecode}, 1);
      chk("hf_flush", {15'd0, flushPipe}, 1);
      nxt(); #1;
      chk("hf_back_run", {15'd0, stallDecode}, 0);
      chk("hf_haltDone", {15'd0, haltDone}, 0);
      repeat (3) nxt();

      // halt drain behind two writers
      nxt(); wr(1);
      nxt(); wr(2);
      nxt(); idValid = 1; idHalt = 1;
      for (int i = 0; i < 3; i++) begin
         nxt(); #1;
         chk("hd_draining", {15'd0, haltDone}, 0);
         chk("hd_stall", {15'd0, stallDecode}, 1);
      end
      nxt(); #1 chk("hd_done", {15'd0, haltDone}, 1);
      nxt(); wr(6); #1;
      chk("hd_done_stays", {15'd0, haltDone}, 1);
      chk("hd_no_issue", {15'd0, bubble}, 1);
      nxt(); exDoBranch = 1; #1 chk("hd_err_before", {15'd0, err}, 0);
      nxt(); #1;
      chk("hd_err_branch", {15'd0, err}, 1);
      chk("hd_still_done", {15'd0, haltDone}, 1);
      chk("hd_stallCnt_hold", stallCnt, 5);
      #1 rst = 0;
      #1;
      chk("hd_rst_haltDone", {15'd0, haltDone}, 0);
      chk("hd_rst_err", {15'd0, err}, 0);
      nxt(); rst = 1;

      // async reset in the middle of a RAW stall
      nxt(); wr(4);
      nxt(); rd1(4); #1 chk("ar_stall", {15'd0, stallDecode}, 1);
      nxt(); rd1(4); #1 chk("ar_stallCnt", stallCnt, 1);
      #1 rst = 0;
      #1;
      chk("ar_sb_cleared", {15'd0, stallDecode}, 0);
      chk("ar_stallCnt_zero", stallCnt, 0);
      nxt(); rst = 1;
      repeat (2) nxt();

      // second branch before the first flush is applied
      nxt(); memBusy = 1; exDoBranch = 1; #1 chk("db_err0", {15'd0, err}, 0);
      nxt(); memBusy = 1; exDoBranch = 1; #1 chk("db_err1", {15'd0, err}, 0);
      nxt(); #1;
      chk("db_err_set", {15'd0, err}, 1);
      chk("db_flush", {15'd0, flushPipe}, 1);
      nxt(); #1 chk("db_err_sticky", {15'd0, err}, 1);
      nxt(); #1 chk("db_err_sticky2", {15'd0, err}, 1);
      #1 rst = 0;
      #1 chk("db_err_rst", {15'd0, err}, 0);
      nxt(); rst = 1;
      nxt();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
